// File: rtl/cpu_irq_dispatch.sv
// CPU-side interrupt dispatch: IE register, IME sequencing, priority select and 5 M-cycle dispatch.
// Optional DISPATCH_CANCEL_EN: select the source late (end of PUSH_HI) and allow a cancelled dispatch.
module cpu_irq_dispatch #(
    parameter logic [15:0] VEC_BASE = 16'h0040,
    parameter int unsigned NUM_IRQ  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mcyc,
    input  logic [NUM_IRQ-1:0] irq_trig,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic               ie_wr,
    input  logic               ie_rd,
    input  logic [7:0]         d_in,
    output logic [7:0]         ie_q,
    input  logic               instr_boundary,
    input  logic               op_ei,
    input  logic               op_di,
    input  logic               op_reti,
    output logic               dispatch,
    output logic               push_hi,
    output logic               push_lo,
    output logic               vec_valid,
    output logic [15:0]        vector,
    output logic               wake,
    output logic               ime_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT0,
        S_WAIT1,
        S_PUSH_HI,
        S_PUSH_LO,
        S_JUMP
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           ie_d;
    logic                 ime_d;
    logic                 ime_pend_q, ime_pend_d;
    logic [2:0]           sel_q, sel_d;
    logic                 sel_vld_q, sel_vld_d;
    logic                 dispatch_q, dispatch_d;
    logic                 push_hi_q, push_hi_d;
    logic                 push_lo_q, push_lo_d;
    logic                 vec_valid_q, vec_valid_d;
    logic [15:0]          vector_q, vector_d;
    logic [NUM_IRQ-1:0]   irq_ack_q, irq_ack_d;
    logic [NUM_IRQ-1:0]   pend;
    logic                 ime_now;
    logic                 start;
`ifdef DISPATCH_CANCEL_EN
    logic [NUM_IRQ-1:0]   pend_sel;
`endif

    // ie_rd only steers the core's read mux; the register itself has no read side effect.
    logic unused_ie_rd;
    assign unused_ie_rd = ie_rd;

    function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (v[i-1]) lowest_idx = 3'(i - 1);
        end
    endfunction

    always_comb begin
        pend = irq_trig & ie_q[NUM_IRQ-1:0];

        ie_d = ie_q;
        if (mcyc && ie_wr) ie_d = d_in;

`ifdef DISPATCH_CANCEL_EN
        // Uses the post-write IE so a push of PC[15:8] onto FFFF can cancel the dispatch.
        pend_sel = irq_trig & ie_d[NUM_IRQ-1:0];
`endif

        // A pending EI takes effect at this boundary, so dispatch may start here.
        ime_now = ime_q | (ime_pend_q & instr_boundary);
        start   = (state_q == S_IDLE) && mcyc && ime_now && (|pend) && instr_boundary;

        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        if (mcyc) begin
            if (ime_pend_q && instr_boundary) begin
                ime_d      = 1'b1;
                ime_pend_d = 1'b0;
            end
            if (op_ei)   ime_pend_d = 1'b1;
            if (op_reti) ime_d      = 1'b1;
            if (op_di || start) begin
                ime_d      = 1'b0;
                ime_pend_d = 1'b0;
            end
        end

        state_d   = state_q;
        sel_d     = sel_q;
        sel_vld_d = sel_vld_q;
        if (mcyc) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WAIT0;
`ifndef DISPATCH_CANCEL_EN
                        sel_d     = lowest_idx(pend);
                        sel_vld_d = 1'b1;
`endif
                    end
                end
                S_WAIT0:   state_d = S_WAIT1;
                S_WAIT1:   state_d = S_PUSH_HI;
                S_PUSH_HI: begin
                    state_d = S_PUSH_LO;
`ifdef DISPATCH_CANCEL_EN
                    sel_d     = lowest_idx(pend_sel);
                    sel_vld_d = |pend_sel;
`endif
                end
                S_PUSH_LO: state_d = S_JUMP;
                S_JUMP:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end

        dispatch_d  = (state_d != S_IDLE);
        push_hi_d   = (state_d == S_PUSH_HI);
        push_lo_d   = (state_d == S_PUSH_LO);
        vec_valid_d = (state_d == S_JUMP);
        vector_d    = '0;
        irq_ack_d   = '0;
        if (state_d == S_JUMP && sel_vld_d) begin
            vector_d  = VEC_BASE + {10'd0, sel_d, 3'b000};
            irq_ack_d = {{(NUM_IRQ-1){1'b0}}, 1'b1} << sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ie_q        <= '0;
            ime_q       <= 1'b0;
            ime_pend_q  <= 1'b0;
            sel_q       <= '0;
            sel_vld_q   <= 1'b0;
            dispatch_q  <= 1'b0;
            push_hi_q   <= 1'b0;
            push_lo_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vector_q    <= '0;
            irq_ack_q   <= '0;
        end else begin
            state_q     <= state_d;
            ie_q        <= ie_d;
            ime_q       <= ime_d;
            ime_pend_q  <= ime_pend_d;
            sel_q       <= sel_d;
            sel_vld_q   <= sel_vld_d;
            dispatch_q  <= dispatch_d;
            push_hi_q   <= push_hi_d;
            push_lo_q   <= push_lo_d;
            vec_valid_q <= vec_valid_d;
            vector_q    <= vector_d;
            irq_ack_q   <= irq_ack_d;
        end
    end

    assign dispatch  = dispatch_q;
    assign push_hi   = push_hi_q;
    assign push_lo   = push_lo_q;
    assign vec_valid = vec_valid_q;
    assign vector    = vector_q;
    assign irq_ack   = irq_ack_q;
    assign wake      = |pend;

endmodule
